// File: rtl/vga_meas_pkg.sv
// Shared constants and types for VGA timing measurement.
// The default timing is the standard 640x480 mode.
package vga_meas_pkg;

  localparam int unsigned CW = 12;

  typedef logic [CW-1:0] meas_t;

  localparam int unsigned DefHPixels     = 640;
  localparam int unsigned DefHPeriod     = 800;
  localparam int unsigned DefVPixels     = 480;
  localparam int unsigned DefVPeriod     = 525;
  localparam int unsigned DefLockFrames  = 2;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop input register with polarity normalisation.
// Emits the active-high level plus leading/trailing edge pulses.
module sync_edge_det #(
  parameter logic ActLevel = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sig_i,
  output logic lvl_o,
  output logic lead_o,
  output logic trail_o
);

  logic s1_d, s1_q;
  logic s2_d, s2_q;

  always_comb begin
    s1_d = (sig_i == ActLevel);
    s2_d = s1_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign lvl_o   = s1_q;
  assign lead_o  = s1_q & ~s2_q;
  assign trail_o = ~s1_q & s2_q;

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates from a raw hsync/vsync/en stream, measures the
// line and frame timing, and declares lock when it matches the expected mode.
module vga_sync_decoder
  import vga_meas_pkg::*;
#(
  parameter logic        H_POL       = 1'b0,
  parameter logic        V_POL       = 1'b0,
  parameter int unsigned H_PIXELS    = DefHPixels,
  parameter int unsigned H_PERIOD    = DefHPeriod,
  parameter int unsigned V_PIXELS    = DefVPixels,
  parameter int unsigned V_PERIOD    = DefVPeriod,
  parameter int unsigned LOCK_FRAMES = DefLockFrames,
  parameter int unsigned CW          = vga_meas_pkg::CW
) (
  input  logic          pixel_clk,
  input  logic          reset,
  input  logic          hsync,
  input  logic          vsync,
  input  logic          en,
  output logic          de_o,
  output logic [CW-1:0] pxl_x,
  output logic [CW-1:0] pxl_y,
  output logic          line_start,
  output logic          frame_start,
  output logic [CW-1:0] h_total,
  output logic [CW-1:0] h_active,
  output logic [CW-1:0] hs_width,
  output logic [CW-1:0] v_total,
  output logic [CW-1:0] v_active,
  output logic          locked,
  output logic          timeout
);

  localparam logic [CW-1:0] CntMax     = '1;
  localparam logic [CW-1:0] One        = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] HPeriod    = CW'(H_PERIOD);
  localparam logic [CW-1:0] HPixels    = CW'(H_PIXELS);
  localparam logic [CW-1:0] VPeriod    = CW'(V_PERIOD);
  localparam logic [CW-1:0] VPixels    = CW'(V_PIXELS);
  localparam logic [CW-1:0] LockFrames = CW'(LOCK_FRAMES);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CntMax) ? v : v + One;
  endfunction

  logic hs_lvl, hs_lead, hs_trail;
  logic vs_lvl, vs_lead, vs_trail;
  logic en_lvl, en_lead, en_trail;
  logic unused_vs;

  sync_edge_det #(.ActLevel(H_POL)) u_hs_det (
    .clk_i   (pixel_clk),
    .rst_i   (reset),
    .sig_i   (hsync),
    .lvl_o   (hs_lvl),
    .lead_o  (hs_lead),
    .trail_o (hs_trail)
  );

  sync_edge_det #(.ActLevel(V_POL)) u_vs_det (
    .clk_i   (pixel_clk),
    .rst_i   (reset),
    .sig_i   (vsync),
    .lvl_o   (vs_lvl),
    .lead_o  (vs_lead),
    .trail_o (vs_trail)
  );

  sync_edge_det #(.ActLevel(1'b1)) u_en_det (
    .clk_i   (pixel_clk),
    .rst_i   (reset),
    .sig_i   (en),
    .lvl_o   (en_lvl),
    .lead_o  (en_lead),
    .trail_o (en_trail)
  );

  assign unused_vs = vs_lvl ^ vs_trail;

  logic          seen_hs_d, seen_hs_q;
  logic          seen_vs_d, seen_vs_q;
  logic [CW-1:0] h_cnt_d, h_cnt_q;
  logic [CW-1:0] v_cnt_d, v_cnt_q;
  logic [CW-1:0] hs_w_d, hs_w_q;
  logic [CW-1:0] de_cnt_d, de_cnt_q;
  logic [CW-1:0] act_cnt_d, act_cnt_q;
  logic          line_had_de_d, line_had_de_q;
  logic          line_err_d, line_err_q;
  logic [CW-1:0] lock_cnt_d, lock_cnt_q;
  logic          de_d, de_q;
  logic [CW-1:0] pxl_x_d, pxl_x_q;
  logic [CW-1:0] pxl_y_d, pxl_y_q;
  logic          line_start_d, line_start_q;
  logic          frame_start_d, frame_start_q;
  logic [CW-1:0] h_total_d, h_total_q;
  logic [CW-1:0] h_active_d, h_active_q;
  logic [CW-1:0] hs_width_d, hs_width_q;
  logic [CW-1:0] v_total_d, v_total_q;
  logic [CW-1:0] v_active_d, v_active_q;
  logic          locked_d, locked_q;
  logic          timeout_d, timeout_q;

  logic          had_de;
  logic          line_bad;
  logic          sat_hit;
  logic          frame_good;
  logic [CW-1:0] frame_act;

  always_comb begin
    had_de     = line_had_de_q | en_trail;
    line_bad   = hs_lead & seen_hs_q & (sat_inc(h_cnt_q) != HPeriod);
    sat_hit    = ~hs_lead & (h_cnt_q == CntMax);
    frame_act  = had_de ? sat_inc(act_cnt_q) : act_cnt_q;
    frame_good = (v_cnt_q == VPeriod) & (frame_act == VPixels) &
                 (h_active_q == HPixels) & ~(line_err_q | line_bad);

    // Horizontal measurement
    seen_hs_d    = seen_hs_q | hs_lead;
    h_cnt_d      = hs_lead ? '0 : sat_inc(h_cnt_q);
    h_total_d    = (hs_lead && seen_hs_q) ? sat_inc(h_cnt_q) : h_total_q;
    line_err_d   = line_err_q | line_bad;
    hs_w_d       = hs_lvl ? (hs_lead ? One : sat_inc(hs_w_q)) : hs_w_q;
    hs_width_d   = hs_trail ? hs_w_q : hs_width_q;
    timeout_d    = hs_lead ? 1'b0 : (sat_hit | timeout_q);
    line_start_d = hs_lead;

    // Active region and coordinates
    de_d       = en_lvl;
    de_cnt_d   = en_lvl ? (en_lead ? One : sat_inc(de_cnt_q)) : de_cnt_q;
    pxl_x_d    = en_lead ? '0 : (en_lvl ? sat_inc(pxl_x_q) : pxl_x_q);
    h_active_d = en_trail ? de_cnt_q : h_active_q;
    pxl_y_d    = en_trail ? sat_inc(pxl_y_q) : pxl_y_q;

    // Vertical measurement
    v_cnt_d       = hs_lead ? sat_inc(v_cnt_q) : v_cnt_q;
    act_cnt_d     = hs_lead ? frame_act : act_cnt_q;
    line_had_de_d = hs_lead ? 1'b0 : had_de;
    seen_vs_d     = seen_vs_q;
    v_total_d     = v_total_q;
    v_active_d    = v_active_q;
    lock_cnt_d    = lock_cnt_q;
    locked_d      = locked_q;
    frame_start_d = vs_lead;

    if (vs_lead) begin
      // A coincident hs edge opens the first line of the new frame.
      v_cnt_d       = hs_lead ? One : '0;
      act_cnt_d     = '0;
      line_had_de_d = 1'b0;
      pxl_y_d       = '0;
      seen_vs_d     = 1'b1;
      line_err_d    = 1'b0;
      if (seen_vs_q) begin
        v_total_d  = v_cnt_q;
        v_active_d = frame_act;
        if (frame_good) begin
          lock_cnt_d = (lock_cnt_q >= LockFrames) ? LockFrames : sat_inc(lock_cnt_q);
          locked_d   = locked_q | (lock_cnt_d == LockFrames);
        end else begin
          lock_cnt_d = '0;
          locked_d   = 1'b0;
        end
      end
    end

    if (sat_hit) begin
      lock_cnt_d = '0;
      locked_d   = 1'b0;
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      seen_hs_q     <= 1'b0;
      seen_vs_q     <= 1'b0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      hs_w_q        <= '0;
      de_cnt_q      <= '0;
      act_cnt_q     <= '0;
      line_had_de_q <= 1'b0;
      line_err_q    <= 1'b0;
      lock_cnt_q    <= '0;
      de_q          <= 1'b0;
      pxl_x_q       <= '0;
      pxl_y_q       <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      h_total_q     <= '0;
      h_active_q    <= '0;
      hs_width_q    <= '0;
      v_total_q     <= '0;
      v_active_q    <= '0;
      locked_q      <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      seen_hs_q     <= seen_hs_d;
      seen_vs_q     <= seen_vs_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      hs_w_q        <= hs_w_d;
      de_cnt_q      <= de_cnt_d;
      act_cnt_q     <= act_cnt_d;
      line_had_de_q <= line_had_de_d;
      line_err_q    <= line_err_d;
      lock_cnt_q    <= lock_cnt_d;
      de_q          <= de_d;
      pxl_x_q       <= pxl_x_d;
      pxl_y_q       <= pxl_y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      h_total_q     <= h_total_d;
      h_active_q    <= h_active_d;
      hs_width_q    <= hs_width_d;
      v_total_q     <= v_total_d;
      v_active_q    <= v_active_d;
      locked_q      <= locked_d;
      timeout_q     <= timeout_d;
    end
  end

  assign de_o        = de_q;
  assign pxl_x       = pxl_x_q;
  assign pxl_y       = pxl_y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign h_total     = h_total_q;
  assign h_active    = h_active_q;
  assign hs_width    = hs_width_q;
  assign v_total     = v_total_q;
  assign v_active    = v_active_q;
  assign locked      = locked_q;
  assign timeout     = timeout_q;

endmodule
